// File: rtl/bpm_record_collector.sv
// Sorts the merged BPM record stream into a per-BPM readback RAM once per
// fast-acquisition cycle and keeps per-cycle bookkeeping for the feedback engine.
module bpm_record_collector #(
  parameter int         DW    = 112,
  parameter int         IDX_W = 8,
  parameter int         NBPM  = 256,
  parameter logic [7:0] MAGIC = 8'hB5,
  parameter int         TMO_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [DW-1:0]    s_tdata,
  input  logic             start,
  input  logic [IDX_W:0]   expected,
  input  logic [TMO_W-1:0] timeout,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [IDX_W:0]   rx_count,
  output logic [15:0]      dup_count,
  output logic [15:0]      bad_count,
  output logic [15:0]      oor_count,
  output logic             restart,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [95:0]      rd_data,
  output logic             rd_present
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W:0] NBPM_L = (IDX_W+1)'(NBPM);

  state_t r_state;
  state_t w_next;

  logic             r_tready;
  logic [IDX_W:0]   r_expected;
  logic [TMO_W-1:0] r_timeout;
  logic [TMO_W-1:0] r_timer;
  logic             r_tmo_en;
  logic [IDX_W:0]   r_rx_count;
  logic [15:0]      r_dup;
  logic [15:0]      r_bad;
  logic [15:0]      r_oor;
  logic             r_timed_out;
  logic             r_restart;
  logic [NBPM-1:0]  r_bitmap;
  logic [95:0]      r_mem [NBPM];
  logic [95:0]      r_rd_data;
  logic             r_rd_present;

  logic             w_beat;
  logic             w_magic_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_seen;
  logic             w_bad;
  logic             w_oor;
  logic             w_dup;
  logic             w_store;
  logic [IDX_W:0]   w_rx_next;
  logic             w_complete;
  logic             w_expire;
  logic             w_set_tmo;
  logic             w_restart_evt;
  logic             w_rd_in_range;

  // Record classification, in priority order: magic, range, duplicate, store.
  assign w_beat     = s_tvalid && r_tready && (r_state == S_COLLECT);
  assign w_magic_ok = (s_tdata[111:104] == MAGIC);
  assign w_idx      = s_tdata[96 +: IDX_W];
  assign w_in_range = ({1'b0, w_idx} < NBPM_L);
  assign w_seen     = w_in_range && r_bitmap[w_idx];
  assign w_bad      = w_beat && !w_magic_ok;
  assign w_oor      = w_beat && w_magic_ok && !w_in_range;
  assign w_dup      = w_beat && w_magic_ok && w_in_range && w_seen;
  assign w_store    = w_beat && w_magic_ok && w_in_range && !w_seen;

  // Exit conditions look at the count including the current beat.
  assign w_rx_next     = r_rx_count + {{IDX_W{1'b0}}, w_store};
  assign w_complete    = (w_rx_next == r_expected);
  assign w_expire      = r_tmo_en && (r_timer == TMO_W'(1));
  assign w_restart_evt = start && (r_state == S_COLLECT);
  assign w_rd_in_range = ({1'b0, rd_addr} < NBPM_L);

  always_comb begin
    w_next    = r_state;
    w_set_tmo = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = start ? S_CLEAR : S_COLLECT;
      S_COLLECT: begin
        if (start) begin
          w_next = S_CLEAR;
        end else if (w_complete) begin
          w_next = S_DONE;
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_set_tmo = 1'b1;
        end
      end
      S_DONE:  w_next = start ? S_CLEAR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_tready    <= 1'b0;
      r_expected  <= '0;
      r_timeout   <= '0;
      r_timer     <= '0;
      r_tmo_en    <= 1'b0;
      r_rx_count  <= '0;
      r_dup       <= '0;
      r_bad       <= '0;
      r_oor       <= '0;
      r_timed_out <= 1'b0;
      r_restart   <= 1'b0;
      r_bitmap    <= '0;
    end else begin
      r_state  <= w_next;
      r_tready <= (w_next == S_IDLE) || (w_next == S_COLLECT);
      if (w_restart_evt) r_restart <= 1'b1;
      // Parameters are captured on the start strobe itself.
      if (start && (w_next == S_CLEAR)) begin
        r_expected <= expected;
        r_timeout  <= timeout;
      end
      if (r_state == S_CLEAR) begin
        r_bitmap    <= '0;
        r_rx_count  <= '0;
        r_dup       <= '0;
        r_bad       <= '0;
        r_oor       <= '0;
        r_timed_out <= 1'b0;
        r_timer     <= r_timeout;
        r_tmo_en    <= (r_timeout != '0);
      end else if (r_state == S_COLLECT) begin
        if (r_tmo_en) r_timer <= r_timer - TMO_W'(1);
        r_rx_count <= w_rx_next;
        if (w_store) r_bitmap[w_idx] <= 1'b1;
        if (w_dup && (r_dup != 16'hFFFF)) r_dup <= r_dup + 16'd1;
        if (w_bad && (r_bad != 16'hFFFF)) r_bad <= r_bad + 16'd1;
        if (w_oor && (r_oor != 16'hFFFF)) r_oor <= r_oor + 16'd1;
        if (w_set_tmo) r_timed_out <= 1'b1;
      end
    end
  end

  // First record for an index wins; RAM itself is never reset.
  always_ff @(posedge aclk) begin
    if (w_store) r_mem[w_idx] <= s_tdata[95:0];
  end

  // Read-first readback: returns data and presence from before this edge's update.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_data    <= '0;
      r_rd_present <= 1'b0;
    end else begin
      r_rd_data    <= w_rd_in_range ? r_mem[rd_addr] : '0;
      r_rd_present <= w_rd_in_range && r_bitmap[rd_addr];
    end
  end

  assign s_tready   = r_tready;
  assign busy       = (r_state == S_COLLECT);
  assign done       = (r_state == S_DONE);
  assign timed_out  = r_timed_out;
  assign rx_count   = r_rx_count;
  assign dup_count  = r_dup;
  assign bad_count  = r_bad;
  assign oor_count  = r_oor;
  assign restart    = r_restart;
  assign rd_data    = r_rd_data;
  assign rd_present = r_rd_present;

endmodule

// File: tb/tb_bpm_record_collector.sv
// Directed bench for bpm_record_collector; a second instance with NBPM=200
// shares the stimulus so out-of-range indices can be exercised.
module tb_bpm_record_collector;

  logic         aclk;
  logic         aresetn;
  logic         s_tvalid;
  logic [111:0] s_tdata;
  logic         start;
  logic [8:0]   expected;
  logic [15:0]  timeout;
  logic [7:0]   rd_addr;

  logic         s_tready, busy, done, timed_out, restart, rd_present;
  logic [8:0]   rx_count;
  logic [15:0]  dup_count, bad_count, oor_count;
  logic [95:0]  rd_data;

  logic         d2_s_tready, d2_busy, d2_done, d2_timed_out, d2_restart, d2_rd_present;
  logic [8:0]   d2_rx_count;
  logic [15:0]  d2_dup_count, d2_bad_count, d2_oor_count;
  logic [95:0]  d2_rd_data;

  int checks = 0;
  int errors = 0;

  bpm_record_collector dut (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .start(start), .expected(expected), .timeout(timeout),
    .busy(busy), .done(done), .timed_out(timed_out), .rx_count(rx_count),
    .dup_count(dup_count), .bad_count(bad_count), .oor_count(oor_count),
    .restart(restart), .rd_addr(rd_addr), .rd_data(rd_data), .rd_present(rd_present)
  );

  bpm_record_collector #(.NBPM(200)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(d2_s_tready),
    .s_tdata(s_tdata), .start(start), .expected(expected), .timeout(timeout),
    .busy(d2_busy), .done(d2_done), .timed_out(d2_timed_out), .rx_count(d2_rx_count),
    .dup_count(d2_dup_count), .bad_count(d2_bad_count), .oor_count(d2_oor_count),
    .restart(d2_restart), .rd_addr(rd_addr), .rd_data(d2_rd_data), .rd_present(d2_rd_present)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_rec(input logic [7:0] m, input logic [7:0] idx,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
    s_tdata  = {m, idx, x, y, s};
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] e, input logic [15:0] t);
    start    = 1'b1;
    expected = e;
    timeout  = t;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; start = 1'b0;
    expected = '0; timeout = '0; rd_addr = '0;
    repeat (3) tick();
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %0b expected 0", s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_timed_out: got %0b expected 0", timed_out); end
    checks++; if (rx_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_rx: got %0d expected 0", rx_count); end
    checks++; if ({dup_count, bad_count, oor_count} !== 48'd0) begin errors++; $display("[TB] FAIL reset_errcnt: got %0h expected 0", {dup_count, bad_count, oor_count}); end
    checks++; if (restart !== 1'b0) begin errors++; $display("[TB] FAIL reset_restart: got %0b expected 0", restart); end
    checks++; if (rd_data !== 96'd0) begin errors++; $display("[TB] FAIL reset_rd_data: got %0h expected 0", rd_data); end
    aresetn = 1'b1;
    repeat (2) tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL idle_tready: got %0b expected 1", s_tready); end
  endtask

  task automatic test_complete();
    do_start(9'd3, 16'd100);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL clear_tready: got %0b expected 0", s_tready); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL collect_busy: got %0b expected 1", busy); end
    send_rec(8'hB5, 8'd5, 32'h0000_0005, 32'h0000_0105, 32'h0000_0205);
    send_rec(8'hB5, 8'd9, 32'h1111_0009, 32'h2222_0009, 32'h3333_0009);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL early_done: got %0b expected 0", done); end
    send_rec(8'hB5, 8'd200, 32'hAAAA_00C8, 32'hBBBB_00C8, 32'hCCCC_00C8);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL complete_done: got %0b expected 1", done); end
    checks++; if (rx_count !== 9'd3) begin errors++; $display("[TB] FAIL complete_rx: got %0d expected 3", rx_count); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL complete_tmo: got %0b expected 0", timed_out); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL done_tready: got %0b expected 0", s_tready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_len: got %0b expected 0", done); end
    rd_addr = 8'd9;
    tick();
    checks++; if (rd_data !== {32'h1111_0009, 32'h2222_0009, 32'h3333_0009}) begin errors++; $display("[TB] FAIL rd9_data: got %0h expected 111100092222000933330009", rd_data); end
    checks++; if (rd_present !== 1'b1) begin errors++; $display("[TB] FAIL rd9_present: got %0b expected 1", rd_present); end
    rd_addr = 8'd6;
    tick();
    checks++; if (rd_present !== 1'b0) begin errors++; $display("[TB] FAIL rd6_present: got %0b expected 0", rd_present); end
  endtask

  task automatic test_timeout();
    int n;
    do_start(9'd4, 16'd20);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) break;
      n++;
      if (n <= 2) begin
        s_tdata  = {8'hB5, 8'(10 + n), 32'(n), 32'd0, 32'd0};
        s_tvalid = 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    checks++; if (n !== 20) begin errors++; $display("[TB] FAIL tmo_cycles: got %0d expected 20", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL tmo_done: got %0b expected 1", done); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("[TB] FAIL tmo_flag: got %0b expected 1", timed_out); end
    checks++; if (rx_count !== 9'd2) begin errors++; $display("[TB] FAIL tmo_rx: got %0d expected 2", rx_count); end
    tick();
  endtask

  task automatic test_idle_drain();
    s_tdata  = {8'hB5, 8'd50, 32'h5, 32'h5, 32'h5};
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL drain_tready: got %0b expected 1", s_tready); end
      tick();
    end
    s_tvalid = 1'b0;
    rd_addr  = 8'd50;
    tick();
    checks++; if (rx_count !== 9'd2) begin errors++; $display("[TB] FAIL drain_rx: got %0d expected 2", rx_count); end
    checks++; if ({dup_count, bad_count, oor_count} !== 48'd0) begin errors++; $display("[TB] FAIL drain_errcnt: got %0h expected 0", {dup_count, bad_count, oor_count}); end
    checks++; if (rd_present !== 1'b0) begin errors++; $display("[TB] FAIL drain_present: got %0b expected 0", rd_present); end
    checks++; if (timed_out !== 1'b1) begin errors++; $display("[TB] FAIL drain_status_hold: got %0b expected 1", timed_out); end
  endtask

  task automatic test_errors();
    do_start(9'd3, 16'd10);
    tick();
    send_rec(8'hB5, 8'd7,   32'd1, 32'h70, 32'h71);
    send_rec(8'hB5, 8'd7,   32'd2, 32'h72, 32'h73);
    send_rec(8'h00, 8'd3,   32'd3, 32'h30, 32'h31);
    send_rec(8'hB5, 8'd255, 32'd4, 32'hF0, 32'hF1);
    for (int i = 0; i < 30 && busy; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL err_done: got %0b expected 1", done); end
    checks++; if (d2_dup_count !== 16'd1) begin errors++; $display("[TB] FAIL err_dup: got %0d expected 1", d2_dup_count); end
    checks++; if (d2_bad_count !== 16'd1) begin errors++; $display("[TB] FAIL err_bad: got %0d expected 1", d2_bad_count); end
    checks++; if (d2_oor_count !== 16'd1) begin errors++; $display("[TB] FAIL err_oor: got %0d expected 1", d2_oor_count); end
    checks++; if (d2_rx_count !== 9'd1) begin errors++; $display("[TB] FAIL err_rx200: got %0d expected 1", d2_rx_count); end
    checks++; if (oor_count !== 16'd0) begin errors++; $display("[TB] FAIL err_oor256: got %0d expected 0", oor_count); end
    checks++; if (rx_count !== 9'd2) begin errors++; $display("[TB] FAIL err_rx256: got %0d expected 2", rx_count); end
    rd_addr = 8'd7;
    tick();
    checks++; if (d2_rd_data[95:64] !== 32'd1) begin errors++; $display("[TB] FAIL err_ram7_x: got %0d expected 1", d2_rd_data[95:64]); end
    checks++; if (rd_data[95:64] !== 32'd1) begin errors++; $display("[TB] FAIL err_ram7_x256: got %0d expected 1", rd_data[95:64]); end
  endtask

  task automatic test_restart();
    do_start(9'd3, 16'd0);
    tick();
    send_rec(8'hB5, 8'd20, 32'h20, 32'h20, 32'h20);
    send_rec(8'hB5, 8'd21, 32'h21, 32'h21, 32'h21);
    checks++; if (rx_count !== 9'd2) begin errors++; $display("[TB] FAIL rs_partial_rx: got %0d expected 2", rx_count); end
    do_start(9'd3, 16'd0);
    checks++; if (restart !== 1'b1) begin errors++; $display("[TB] FAIL rs_flag: got %0b expected 1", restart); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rs_no_done: got %0b expected 0", done); end
    tick();
    checks++; if (rx_count !== 9'd0) begin errors++; $display("[TB] FAIL rs_rx_cleared: got %0d expected 0", rx_count); end
    rd_addr = 8'd20;
    send_rec(8'hB5, 8'd30, 32'h30, 32'h30, 32'h30);
    checks++; if (rd_present !== 1'b0) begin errors++; $display("[TB] FAIL rs_bitmap_cleared: got %0b expected 0", rd_present); end
    send_rec(8'hB5, 8'd31, 32'h31, 32'h31, 32'h31);
    send_rec(8'hB5, 8'd32, 32'h32, 32'h32, 32'h32);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rs_new_done: got %0b expected 1", done); end
    checks++; if (rx_count !== 9'd3) begin errors++; $display("[TB] FAIL rs_new_rx: got %0d expected 3", rx_count); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_start(9'd1, 16'd1);
    tick();
    send_rec(8'hB5, 8'd40, 32'h40, 32'h40, 32'h40);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL tie_done: got %0b expected 1", done); end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL tie_tmo: got %0b expected 0", timed_out); end
    tick();
    do_start(9'd0, 16'd0);
    tick();
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL exp0_done: got %0b expected 1", done); end
    checks++; if (rx_count !== 9'd0) begin errors++; $display("[TB] FAIL exp0_rx: got %0d expected 0", rx_count); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(9'd5, 16'd0);
    tick();
    send_rec(8'hB5, 8'd60, 32'h60, 32'h60, 32'h60);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rm_busy_before: got %0b expected 1", busy); end
    aresetn = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %0b expected 0", busy); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL rm_tready: got %0b expected 0", s_tready); end
    checks++; if (rx_count !== 9'd0) begin errors++; $display("[TB] FAIL rm_rx: got %0d expected 0", rx_count); end
    checks++; if (restart !== 1'b0) begin errors++; $display("[TB] FAIL rm_restart: got %0b expected 0", restart); end
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_done: got %0b expected 0", done); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_complete();
    test_timeout();
    test_idle_drain();
    test_errors();
    test_restart();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
